// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V op encodings and branch-predictor constants
package riscv_pkg;

    localparam int NB_OPERATION = 6;

    localparam int OP_BEQ  = 0;
    localparam int OP_BNE  = 1;
    localparam int OP_BLT  = 2;
    localparam int OP_BGE  = 3;
    localparam int OP_JAL  = 4;
    localparam int OP_JALR = 5;

    localparam logic [1:0] CNT_MIN    = 2'b00;
    localparam logic [1:0] CNT_WEAK_T = 2'b10;
    localparam logic [1:0] CNT_MAX    = 2'b11;

endpackage

// File: rtl/bu_bpred_if.sv
// rtl/bu_bpred_if.sv - execute-stage request/resolution bundle of the branch unit
interface bu_bpred_if
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
);
    logic                    bu_en_i;
    logic [NB_OPERATION-1:0] cmd_i;
    logic                    unsign_cmp_i;
    logic [XLEN-1:0]         rs1_data_i;
    logic [XLEN-1:0]         rs2_data_i;
    logic [XLEN-1:0]         immediat_i;
    logic [XLEN-1:0]         pc_data_i;
    logic                    pred_taken_i;
    logic [XLEN-1:0]         pred_target_i;
    logic                    flush_i;

    logic                    res_v_o;
    logic                    redirect_o;
    logic [XLEN-1:0]         redirect_pc_o;
    logic [XLEN-1:0]         data_o;
    logic                    pc_missaligned_o;

    modport master (
        output bu_en_i, cmd_i, unsign_cmp_i, rs1_data_i, rs2_data_i, immediat_i,
               pc_data_i, pred_taken_i, pred_target_i, flush_i,
        input  res_v_o, redirect_o, redirect_pc_o, data_o, pc_missaligned_o
    );

    modport slave (
        input  bu_en_i, cmd_i, unsign_cmp_i, rs1_data_i, rs2_data_i, immediat_i,
               pc_data_i, pred_taken_i, pred_target_i, flush_i,
        output res_v_o, redirect_o, redirect_pc_o, data_o, pc_missaligned_o
    );
endinterface

// File: rtl/bu_btb.sv
// rtl/bu_btb.sv - direct-mapped BTB with 2-bit direction counters
module bu_btb
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:2] lk_pc,
    output logic            lk_taken,
    output logic [XLEN-1:0] lk_target,
    input  logic            up_en,
    input  logic [XLEN-1:2] up_pc,
    input  logic            up_taken,
    input  logic [XLEN-1:0] up_target
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = XLEN - IDX_W - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [1:0]       cnt;
    } btb_entry_t;

    // Only valid bits are reset; the payload arrays are qualified by them.
    logic [BTB_DEPTH-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
    logic [XLEN-1:0]      target_q [BTB_DEPTH];
    logic [1:0]           cnt_q    [BTB_DEPTH];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    btb_entry_t       lk_e, up_e;
    logic             lk_hit, up_hit;
    logic [1:0]       cnt_nx;

    assign lk_idx = lk_pc[IDX_W+1:2];
    assign lk_tag = lk_pc[XLEN-1:IDX_W+2];
    assign up_idx = up_pc[IDX_W+1:2];
    assign up_tag = up_pc[XLEN-1:IDX_W+2];

    always_comb begin
        lk_e = '{valid: valid_q[lk_idx], tag: tag_q[lk_idx], target: target_q[lk_idx], cnt: cnt_q[lk_idx]};
        up_e = '{valid: valid_q[up_idx], tag: tag_q[up_idx], target: target_q[up_idx], cnt: cnt_q[up_idx]};
    end

    assign lk_hit    = lk_e.valid & (lk_e.tag == lk_tag);
    assign lk_taken  = lk_hit & lk_e.cnt[1];
    assign lk_target = lk_taken ? lk_e.target : '0;
    assign up_hit    = up_e.valid & (up_e.tag == up_tag);

    always_comb begin
        cnt_nx = up_e.cnt;
        if (up_taken && up_e.cnt != CNT_MAX)
            cnt_nx = up_e.cnt + 2'd1;
        else if (!up_taken && up_e.cnt != CNT_MIN)
            cnt_nx = up_e.cnt - 2'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            valid_q <= '0;
        else if (up_en && !up_hit && up_taken)
            valid_q[up_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (up_en) begin
            if (up_hit) begin
                cnt_q[up_idx] <= cnt_nx;
                if (up_taken)
                    target_q[up_idx] <= up_target;
            end else if (up_taken) begin
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= up_target;
                cnt_q[up_idx]    <= CNT_WEAK_T;
            end
        end
    end
endmodule

// File: rtl/bu_bpred.sv
// rtl/bu_bpred.sv - branch resolution, mispredict redirect and BTB owner
module bu_bpred
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            if_pred_taken_o,
    output logic [XLEN-1:0] if_pred_target_o,
    bu_bpred_if.slave       ex,
    output logic [31:0]     mispred_cnt_o
);
    logic            act, eq, lt, taken, misal, mispred, is_jalr;
    logic [XLEN:0]   op_a, op_b, diff;
    logic [XLEN-1:0] sum_jalr, target, link, next_pc;
    logic            unused_pc_lsb;

    logic            res_v_q, redirect_q, misal_q;
    logic [XLEN-1:0] redirect_pc_q, data_q;

    assign act     = ex.bu_en_i & ~ex.flush_i;
    assign is_jalr = ex.cmd_i[OP_JALR];

    // One extra bit lets a single subtractor serve both signed and unsigned compares.
    assign op_a = {~ex.unsign_cmp_i & ex.rs1_data_i[XLEN-1], ex.rs1_data_i};
    assign op_b = {~ex.unsign_cmp_i & ex.rs2_data_i[XLEN-1], ex.rs2_data_i};
    assign diff = op_a - op_b;
    assign lt   = diff[XLEN];
    assign eq   = (ex.rs1_data_i == ex.rs2_data_i);

    assign taken = (ex.cmd_i[OP_BEQ] & eq) | (ex.cmd_i[OP_BNE] & ~eq)
                 | (ex.cmd_i[OP_BLT] & lt) | (ex.cmd_i[OP_BGE] & ~lt)
                 | ex.cmd_i[OP_JAL] | is_jalr;

    assign sum_jalr = ex.rs1_data_i + ex.immediat_i;
    assign target   = is_jalr ? {sum_jalr[XLEN-1:1], 1'b0} : ex.pc_data_i + ex.immediat_i;
    assign misal    = taken & (is_jalr ? target[1] : |target[1:0]);
    assign link     = ex.pc_data_i + XLEN'(4);
    assign next_pc  = taken ? target : link;
    assign mispred  = act & ~misal
                    & ((taken != ex.pred_taken_i) | (taken & (ex.pred_target_i != target)));

    assign unused_pc_lsb = ^if_pc_i[1:0];

    bu_btb #(.XLEN(XLEN), .BTB_DEPTH(BTB_DEPTH)) u_btb (
        .clk       (clk),
        .reset_n   (reset_n),
        .lk_pc     (if_pc_i[XLEN-1:2]),
        .lk_taken  (if_pred_taken_o),
        .lk_target (if_pred_target_o),
        .up_en     (act & ~misal),
        .up_pc     (ex.pc_data_i[XLEN-1:2]),
        .up_taken  (taken),
        .up_target (target)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_v_q       <= 1'b0;
            redirect_q    <= 1'b0;
            misal_q       <= 1'b0;
            redirect_pc_q <= '0;
            data_q        <= '0;
            mispred_cnt_o <= '0;
        end else begin
            res_v_q    <= act;
            redirect_q <= mispred;
            misal_q    <= act & misal;
            if (act) begin
                redirect_pc_q <= next_pc;
                data_q        <= link;
            end
            if (mispred && mispred_cnt_o != 32'hFFFF_FFFF)
                mispred_cnt_o <= mispred_cnt_o + 32'd1;
        end
    end

    assign ex.res_v_o          = res_v_q;
    assign ex.redirect_o       = redirect_q;
    assign ex.redirect_pc_o    = redirect_pc_q;
    assign ex.data_o           = data_q;
    assign ex.pc_missaligned_o = misal_q;
endmodule

// File: tb/tb_bu_bpred.sv
// tb/tb_bu_bpred.sv - scoreboard bench for bu_bpred
module tb_bu_bpred;
    import riscv_pkg::*;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] data;
        logic        misal;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] if_pc = '0;
    logic        if_pt;
    logic [31:0] if_ptgt;
    logic [31:0] mcnt_o;

    int n_chk = 0;
    int n_err = 0;
    exp_t sb[$];

    bit          mv   [64];
    logic [23:0] mtag [64];
    logic [31:0] mtgt [64];
    logic [1:0]  mcnt [64];
    logic [31:0] m_mis = '0;

    always #5 clk = ~clk;

    bu_bpred_if #(.XLEN(32)) ex();

    bu_bpred #(.XLEN(32), .BTB_DEPTH(64)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .if_pc_i          (if_pc),
        .if_pred_taken_o  (if_pt),
        .if_pred_target_o (if_ptgt),
        .ex               (ex),
        .mispred_cnt_o    (mcnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic mlook(input logic [31:0] pc, output logic t, output logic [31:0] g);
        int i;
        i = int'(pc[7:2]);
        t = mv[i] && (mtag[i] == pc[31:8]) && mcnt[i][1];
        g = t ? mtgt[i] : 32'h0;
    endtask

    task automatic look(input logic [31:0] pc);
        logic        t;
        logic [31:0] g;
        if_pc = pc;
        #1;
        mlook(pc, t, g);
        chk("lk_taken", if_pt, t);
        chk("lk_target", if_ptgt, g);
    endtask

    task automatic do_op(input int op, input logic uns, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic pt,
                         input logic [31:0] ptgt, input logic fl);
        logic        eq, lt, tk, mis, ms, hit;
        logic [31:0] tgt;
        exp_t        e;
        int          i;
        @(negedge clk);
        ex.bu_en_i = 1'b1; ex.flush_i = fl; ex.cmd_i = '0; ex.cmd_i[op] = 1'b1;
        ex.unsign_cmp_i = uns; ex.rs1_data_i = rs1; ex.rs2_data_i = rs2; ex.immediat_i = imm;
        ex.pc_data_i = pc; ex.pred_taken_i = pt; ex.pred_target_i = ptgt;
        eq = (rs1 == rs2);
        lt = uns ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));
        case (op)
            OP_BEQ:  tk = eq;
            OP_BNE:  tk = !eq;
            OP_BLT:  tk = lt;
            OP_BGE:  tk = !lt;
            default: tk = 1'b1;
        endcase
        tgt = (op == OP_JALR) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        ms  = tk && ((op == OP_JALR) ? tgt[1] : (tgt[1:0] != 2'b00));
        mis = !fl && !ms && ((tk != pt) || (tk && ptgt != tgt));
        if (mis && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
        if (!fl) begin
            e.redir = mis; e.rpc = tk ? tgt : pc + 4; e.data = pc + 4; e.misal = ms; e.cnt = m_mis;
            sb.push_back(e);
            if (!ms) begin
                i = int'(pc[7:2]);
                hit = mv[i] && (mtag[i] == pc[31:8]);
                if (hit) begin
                    if (tk) begin
                        if (mcnt[i] != 2'b11) mcnt[i] = mcnt[i] + 1;
                        mtgt[i] = tgt;
                    end else if (mcnt[i] != 2'b00) mcnt[i] = mcnt[i] - 1;
                end else if (tk) begin
                    mv[i] = 1'b1; mtag[i] = pc[31:8]; mtgt[i] = tgt; mcnt[i] = 2'b10;
                end
            end
        end
        @(negedge clk);
        ex.bu_en_i = 1'b0; ex.flush_i = 1'b0;
        if (fl) chk("flush_res_v", ex.res_v_o, 0);
        @(negedge clk);
        chk("idle_res_v", ex.res_v_o, 0);
        chk("idle_redirect", ex.redirect_o, 0);
    endtask

    task automatic op_pred(input int op, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input logic [31:0] pc);
        logic        t;
        logic [31:0] g;
        mlook(pc, t, g);
        do_op(op, 1'b0, rs1, rs2, imm, pc, t, g, 1'b0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (reset_n && ex.res_v_o) begin
            if (sb.size() == 0) chk("spurious_res_v", 1, 0);
            else begin
                e = sb.pop_front();
                chk("redirect", ex.redirect_o, e.redir);
                chk("redirect_pc", ex.redirect_pc_o, e.rpc);
                chk("data", ex.data_o, e.data);
                chk("missaligned", ex.pc_missaligned_o, e.misal);
                chk("mispred_cnt", mcnt_o, e.cnt);
            end
        end
    end

    initial begin
        logic [31:0] vals [4];
        logic [31:0] pc, imm;
        int          op;
        vals[0] = 32'h0; vals[1] = 32'h1; vals[2] = 32'hFFFF_FFFF; vals[3] = 32'h8000_0000;
        ex.bu_en_i = 0; ex.flush_i = 0; ex.cmd_i = '0; ex.unsign_cmp_i = 0; ex.rs1_data_i = '0;
        ex.rs2_data_i = '0; ex.immediat_i = '0; ex.pc_data_i = '0; ex.pred_taken_i = 0; ex.pred_target_i = '0;
        for (int i = 0; i < 64; i++) begin mv[i] = 0; mcnt[i] = '0; end

        repeat (2) @(negedge clk);
        chk("rst_res_v", ex.res_v_o, 0);
        chk("rst_redirect", ex.redirect_o, 0);
        chk("rst_redirect_pc", ex.redirect_pc_o, 0);
        chk("rst_data", ex.data_o, 0);
        chk("rst_misal", ex.pc_missaligned_o, 0);
        chk("rst_cnt", mcnt_o, 0);
        look(32'h100);
        @(negedge clk);
        reset_n = 1'b1;

        do_op(OP_BEQ, 0, 5, 5, 32'h20, 32'h100, 0, 0, 0);
        look(32'h100);
        chk("beq_alloc_target", if_ptgt, 32'h120);
        do_op(OP_BLT, 0, 32'hFFFF_FFFF, 1, 32'h40, 32'h300, 0, 0, 0);
        do_op(OP_BLT, 1, 32'hFFFF_FFFF, 1, 32'h40, 32'h400, 0, 0, 0);
        do_op(OP_BGE, 1, 7, 7, 32'hFFFF_FFF8, 32'h500, 0, 0, 0);
        do_op(OP_JAL, 0, 0, 0, 32'h100, 32'h600, 1, 32'h700, 0);
        do_op(OP_JAL, 0, 0, 0, 32'h100, 32'h600, 1, 32'h800, 0);
        do_op(OP_JALR, 0, 32'h1003, 0, 0, 32'h200, 0, 0, 0);
        look(32'h200);

        repeat (4) op_pred(OP_BEQ, 1, 1, 32'h20, 32'h100);
        look(32'h100);
        look(32'h100 + 4 * 64);
        chk("alias_miss", if_pt, 0);
        op_pred(OP_BNE, 1, 1, 32'h20, 32'h100);
        look(32'h100);
        chk("sat_still_taken", if_pt, 1);
        repeat (2) op_pred(OP_BNE, 1, 1, 32'h20, 32'h100);
        look(32'h100);
        chk("sat_now_not_taken", if_pt, 0);

        do_op(OP_BEQ, 0, 3, 3, 32'h40, 32'h700, 0, 0, 1);
        chk("flush_cnt", mcnt_o, m_mis);
        look(32'h700);

        for (int k = 0; k < 24; k++) begin
            op  = $urandom_range(0, 5);
            pc  = 32'h1000 + 4 * $urandom_range(0, 3) + 256 * $urandom_range(0, 1);
            imm = ($urandom_range(0, 7) == 0) ? 32'h2 : 4 * $urandom_range(0, 16) - 32;
            look(pc);
            op_pred(op, vals[$urandom_range(0, 3)], vals[$urandom_range(0, 3)], imm, pc);
        end

        @(negedge clk);
        if_pc = 32'h100;
        ex.bu_en_i = 1; ex.cmd_i = '0; ex.cmd_i[OP_BEQ] = 1'b1; ex.unsign_cmp_i = 0;
        ex.rs1_data_i = 9; ex.rs2_data_i = 9; ex.immediat_i = 32'h20; ex.pc_data_i = 32'h100;
        ex.pred_taken_i = 0; ex.pred_target_i = 0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 ex.bu_en_i = 0;
        chk("arst_res_v", ex.res_v_o, 0);
        chk("arst_redirect", ex.redirect_o, 0);
        chk("arst_redirect_pc", ex.redirect_pc_o, 0);
        chk("arst_data", ex.data_o, 0);
        chk("arst_cnt", mcnt_o, 0);
        chk("arst_lk_taken", if_pt, 0);
        for (int i = 0; i < 64; i++) mv[i] = 0;
        m_mis = '0;
        @(negedge clk);
        reset_n = 1'b1;
        look(32'h100);
        do_op(OP_JAL, 0, 0, 0, 32'h8, 32'h40, 0, 0, 0);
        look(32'h40);

        chk("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
